// File: rtl/idexe_hazard_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared widths, control-bundle bit indices, ALUOp encodings and
//            the hazard FSM state type for the ID/EX stage of the RV32I core.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package pipe_pkg;

    localparam int REG_W = 5;       // register index width
    localparam int WB_W  = 2;       // write-back control bundle
    localparam int M_W   = 2;       // memory control bundle
    localparam int EX_W  = 4;       // execute control bundle

    // WB bundle bit positions
    localparam int WB_REGWRITE  = 0;
    localparam int WB_MEMTOREG  = 1;

    // M bundle bit positions
    localparam int M_MEMREAD    = 0;
    localparam int M_MEMWRITE   = 1;

    // EX bundle bit positions
    localparam int EX_ALUSRC    = 0;
    localparam int EX_ALUOP_LSB = 1;
    localparam int EX_ALUOP_MSB = 2;
    localparam int EX_BRANCH    = 3;

    // ALUOp encodings carried in EX[2:1]
    localparam logic [1:0] ALUOP_ADD   = 2'b00;  // loads / stores
    localparam logic [1:0] ALUOP_SUB   = 2'b01;  // branch compare
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;  // funct3/funct7 decode
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;  // funct3 decode, immediate

    // Hazard control state
    typedef enum logic [0:0] {
        RUN   = 1'b0,
        STALL = 1'b1
    } hz_state_t;

    // True when a destination register feeds either source of the next op.
    function automatic logic src_match(input logic [REG_W-1:0] rd,
                                       input logic [REG_W-1:0] rs1,
                                       input logic [REG_W-1:0] rs2);
        return (rd == rs1) || (rd == rs2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/idexe_hazard_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : idexe_hazard_stage_if
// Purpose  : Bundle of decoded ID-stage fields (ID_*) and their registered
//            ID/EX copies (IDEXE_*).
// Modports : master - drives ID_*, observes IDEXE_* (decode side / bench)
//            slave  - consumes ID_*, drives IDEXE_* (pipeline register)
// Revision : 1.0  initial release
// ============================================================================
interface idexe_hazard_stage_if #(
    parameter int DATA_W = 32
);
    import pipe_pkg::*;

    logic                ID_Valid;
    logic [REG_W-1:0]    ID_RS1;
    logic [REG_W-1:0]    ID_RS2;
    logic [REG_W-1:0]    ID_RD;
    logic [DATA_W-1:0]   ID_RS1data;
    logic [DATA_W-1:0]   ID_RS2data;
    logic [DATA_W-1:0]   ID_Imm;
    logic [DATA_W-1:0]   ID_PC;
    logic [WB_W-1:0]     ID_WB;
    logic [M_W-1:0]      ID_M;
    logic [EX_W-1:0]     ID_EX;

    logic                IDEXE_Valid;
    logic [REG_W-1:0]    IDEXE_RS1;
    logic [REG_W-1:0]    IDEXE_RS2;
    logic [REG_W-1:0]    IDEXE_RD;
    logic [DATA_W-1:0]   IDEXE_RS1data;
    logic [DATA_W-1:0]   IDEXE_RS2data;
    logic [DATA_W-1:0]   IDEXE_Imm;
    logic [DATA_W-1:0]   IDEXE_PC;
    logic [WB_W-1:0]     IDEXE_WB;
    logic [M_W-1:0]      IDEXE_M;
    logic [EX_W-1:0]     IDEXE_EX;

    modport master (
        output ID_Valid, ID_RS1, ID_RS2, ID_RD, ID_RS1data, ID_RS2data,
               ID_Imm, ID_PC, ID_WB, ID_M, ID_EX,
        input  IDEXE_Valid, IDEXE_RS1, IDEXE_RS2, IDEXE_RD, IDEXE_RS1data,
               IDEXE_RS2data, IDEXE_Imm, IDEXE_PC, IDEXE_WB, IDEXE_M, IDEXE_EX
    );

    modport slave (
        input  ID_Valid, ID_RS1, ID_RS2, ID_RD, ID_RS1data, ID_RS2data,
               ID_Imm, ID_PC, ID_WB, ID_M, ID_EX,
        output IDEXE_Valid, IDEXE_RS1, IDEXE_RS2, IDEXE_RD, IDEXE_RS1data,
               IDEXE_RS2data, IDEXE_Imm, IDEXE_PC, IDEXE_WB, IDEXE_M, IDEXE_EX
    );

endinterface
`default_nettype wire

// File: rtl/idexe_hazard_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_reg_en_clr
// Purpose  : Generic WIDTH-bit pipeline register with asynchronous active-low
//            reset, synchronous clear (bubble insertion) and load enable.
// Ports    : clk_i  clock, rising edge
//            rst_i  asynchronous reset, active low
//            en     load d when set
//            clr    load all zeros (takes precedence over en)
//            d / q  data in / registered data out
// Revision : 1.0  initial release
// ============================================================================
module pipe_reg_en_clr #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/idexe_hazard_stage.sv
`default_nettype none
// ============================================================================
// Module   : idexe_hazard_stage
// Purpose  : ID/EX pipeline register with load-use hazard stall control and
//            taken-branch flush-to-bubble for the 5-stage RV32I core.
// Ports    : clk_i        clock, rising edge
//            rst_i        asynchronous reset, active low
//            bus          ID_* in, IDEXE_* out (idexe_hazard_stage_if.slave)
//            EXE_Flush    EX resolved a taken branch/jump this cycle
//            PC_Write     1 = PC may update (combinational)
//            IFID_Write   1 = IF/ID may load (combinational)
//            Stall_Count  saturating count of load-use bubble cycles
// Revision : 1.0  initial release
// ============================================================================
module idexe_hazard_stage
    import pipe_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int DATA_W            = 32,
    parameter int CNT_W             = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    idexe_hazard_stage_if.slave  bus,
    input  logic                 EXE_Flush,
    output logic                 PC_Write,
    output logic                 IFID_Write,
    output logic [CNT_W-1:0]     Stall_Count
);

    localparam int c_CTRL_W = 1 + WB_W + M_W + EX_W;
    localparam int c_IDX_W  = 3 * REG_W;
    localparam int c_DAT_W  = 4 * DATA_W;

    // Remaining-bubble counter only needs to hold LOAD_STALL_CYCLES-2.
    localparam int c_CW       = (LOAD_STALL_CYCLES > 1) ? $clog2(LOAD_STALL_CYCLES) : 1;
    localparam int c_CNT_LD_I = (LOAD_STALL_CYCLES > 1) ? (LOAD_STALL_CYCLES - 2) : 0;
    localparam logic [c_CW-1:0] c_CNT_LD = c_CNT_LD_I[c_CW-1:0];

    // ------------------------------------------------------------------
    // Pipeline register field groups
    // ------------------------------------------------------------------
    logic [c_CTRL_W-1:0] w_ctrl_d, w_ctrl_q;
    logic [c_IDX_W-1:0]  w_idx_d,  w_idx_q;
    logic [c_DAT_W-1:0]  w_dat_d,  w_dat_q;
    logic                w_bubble;

    logic                w_q_valid;
    logic [WB_W-1:0]     w_q_wb;
    logic [M_W-1:0]      w_q_m;
    logic [EX_W-1:0]     w_q_ex;
    logic [REG_W-1:0]    w_q_rs1, w_q_rs2, w_q_rd;

    assign w_ctrl_d = {bus.ID_Valid, bus.ID_WB, bus.ID_M, bus.ID_EX};
    assign w_idx_d  = {bus.ID_RS1, bus.ID_RS2, bus.ID_RD};
    assign w_dat_d  = {bus.ID_RS1data, bus.ID_RS2data, bus.ID_Imm, bus.ID_PC};

    pipe_reg_en_clr #(.WIDTH(c_CTRL_W)) u_reg_ctrl (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (1'b1),
        .clr   (w_bubble),
        .d     (w_ctrl_d),
        .q     (w_ctrl_q)
    );

    pipe_reg_en_clr #(.WIDTH(c_IDX_W)) u_reg_idx (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (1'b1),
        .clr   (w_bubble),
        .d     (w_idx_d),
        .q     (w_idx_q)
    );

    pipe_reg_en_clr #(.WIDTH(c_DAT_W)) u_reg_dat (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (1'b1),
        .clr   (w_bubble),
        .d     (w_dat_d),
        .q     (w_dat_q)
    );

    assign {w_q_valid, w_q_wb, w_q_m, w_q_ex} = w_ctrl_q;
    assign {w_q_rs1, w_q_rs2, w_q_rd}         = w_idx_q;

    assign bus.IDEXE_Valid = w_q_valid;
    assign bus.IDEXE_WB    = w_q_wb;
    assign bus.IDEXE_M     = w_q_m;
    assign bus.IDEXE_EX    = w_q_ex;
    assign bus.IDEXE_RS1   = w_q_rs1;
    assign bus.IDEXE_RS2   = w_q_rs2;
    assign bus.IDEXE_RD    = w_q_rd;
    assign {bus.IDEXE_RS1data, bus.IDEXE_RS2data,
            bus.IDEXE_Imm, bus.IDEXE_PC} = w_dat_q;

    // ------------------------------------------------------------------
    // Load-use detect: a valid load in ID/EX writing a non-zero register
    // that the valid instruction in ID reads.
    // ------------------------------------------------------------------
    logic w_hz;

    assign w_hz = bus.ID_Valid & w_q_valid & w_q_m[M_MEMREAD]
                & (w_q_rd != '0)
                & src_match(w_q_rd, bus.ID_RS1, bus.ID_RS2);

    // ------------------------------------------------------------------
    // Hazard FSM
    // ------------------------------------------------------------------
    hz_state_t         r_state, w_state_nxt;
    logic [c_CW-1:0]   r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              w_write_en;
    logic              w_stall_inc;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= RUN;
            r_cnt       <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    // Priority: flush, then an ongoing stall, then a new hazard, else load.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bubble    = 1'b0;
        w_write_en  = 1'b1;
        w_stall_inc = 1'b0;

        if (EXE_Flush) begin
            w_bubble    = 1'b1;
            w_state_nxt = RUN;
            w_cnt_nxt   = '0;
        end else if (r_state == STALL) begin
            w_bubble    = 1'b1;
            w_write_en  = 1'b0;
            w_stall_inc = 1'b1;
            if (r_cnt == '0) begin
                w_state_nxt = RUN;
            end else begin
                w_cnt_nxt = r_cnt - c_CW'(1);
            end
        end else if (w_hz) begin
            w_bubble    = 1'b1;
            w_write_en  = 1'b0;
            w_stall_inc = 1'b1;
            // The hazard cycle itself is the first bubble; STALL covers the rest.
            if (LOAD_STALL_CYCLES > 1) begin
                w_state_nxt = STALL;
                w_cnt_nxt   = c_CNT_LD;
            end
        end
    end

    assign PC_Write    = w_write_en;
    assign IFID_Write  = w_write_en;
    assign Stall_Count = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_idexe_hazard_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_idexe_hazard_stage
// Purpose  : Self-checking bench for idexe_hazard_stage. Two instances share
//            one ID stimulus stream: A (1 bubble/hazard, 4-bit counter) and
//            B (3 bubbles/hazard, 16-bit counter). A behavioural model tracks
//            the expected ID/EX contents, bubbles still owed and stall count.
// Revision : 1.0  initial release
// ============================================================================
module tb_idexe_hazard_stage;
    import pipe_pkg::*;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] rs1data;
        logic [31:0] rs2data;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [1:0]  wb;
        logic [1:0]  m;
        logic [3:0]  ex;
    } id_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    logic flush = 1'b0;
    always #5 clk_i = ~clk_i;

    logic        pcw_a, ifw_a, pcw_b, ifw_b;
    logic [3:0]  sc_a;
    logic [15:0] sc_b;

    idexe_hazard_stage_if #(.DATA_W(32)) bus_a ();
    idexe_hazard_stage_if #(.DATA_W(32)) bus_b ();

    idexe_hazard_stage #(.LOAD_STALL_CYCLES(1), .DATA_W(32), .CNT_W(4)) dut_a (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .bus         (bus_a.slave),
        .EXE_Flush   (flush),
        .PC_Write    (pcw_a),
        .IFID_Write  (ifw_a),
        .Stall_Count (sc_a)
    );

    idexe_hazard_stage #(.LOAD_STALL_CYCLES(3), .DATA_W(32), .CNT_W(16)) dut_b (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .bus         (bus_b.slave),
        .EXE_Flush   (flush),
        .PC_Write    (pcw_b),
        .IFID_Write  (ifw_b),
        .Stall_Count (sc_b)
    );

    int  n_vec = 0;
    int  n_err = 0;

    // Reference model state
    id_t cur;
    id_t m_reg [2];
    int  m_rem [2];
    int  m_cnt [2];
    int  lsc   [2] = '{1, 3};
    int  cmax  [2] = '{15, 65535};

    task automatic drive(input id_t v, input logic f);
        cur   = v;
        flush = f;
        bus_a.ID_Valid = v.valid;   bus_b.ID_Valid = v.valid;
        bus_a.ID_RS1   = v.rs1;     bus_b.ID_RS1   = v.rs1;
        bus_a.ID_RS2   = v.rs2;     bus_b.ID_RS2   = v.rs2;
        bus_a.ID_RD    = v.rd;      bus_b.ID_RD    = v.rd;
        bus_a.ID_RS1data = v.rs1data; bus_b.ID_RS1data = v.rs1data;
        bus_a.ID_RS2data = v.rs2data; bus_b.ID_RS2data = v.rs2data;
        bus_a.ID_Imm   = v.imm;     bus_b.ID_Imm   = v.imm;
        bus_a.ID_PC    = v.pc;      bus_b.ID_PC    = v.pc;
        bus_a.ID_WB    = v.wb;      bus_b.ID_WB    = v.wb;
        bus_a.ID_M     = v.m;       bus_b.ID_M     = v.m;
        bus_a.ID_EX    = v.ex;      bus_b.ID_EX    = v.ex;
    endtask

    function automatic id_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [1:0] wb,
                               input logic [1:0] m, input logic [3:0] ex);
        id_t r;
        r.valid = v;  r.rs1 = rs1; r.rs2 = rs2; r.rd = rd;
        r.rs1data = $urandom; r.rs2data = $urandom;
        r.imm = $urandom;     r.pc = $urandom;
        r.wb = wb; r.m = m; r.ex = ex;
        return r;
    endfunction

    // Load-use rule written straight from the instruction semantics.
    function automatic logic model_hz(input int k);
        return cur.valid && m_reg[k].valid && m_reg[k].m[0] && (m_reg[k].rd != 5'd0)
               && ((m_reg[k].rd == cur.rs1) || (m_reg[k].rd == cur.rs2));
    endfunction

    function automatic logic model_pcw(input int k);
        if (flush)          return 1'b1;
        if (m_rem[k] > 0)   return 1'b0;
        return !model_hz(k);
    endfunction

    function automatic id_t obs(input int k);
        id_t r;
        if (k == 0) begin
            r = {bus_a.IDEXE_Valid, bus_a.IDEXE_RS1, bus_a.IDEXE_RS2, bus_a.IDEXE_RD,
                 bus_a.IDEXE_RS1data, bus_a.IDEXE_RS2data, bus_a.IDEXE_Imm, bus_a.IDEXE_PC,
                 bus_a.IDEXE_WB, bus_a.IDEXE_M, bus_a.IDEXE_EX};
        end else begin
            r = {bus_b.IDEXE_Valid, bus_b.IDEXE_RS1, bus_b.IDEXE_RS2, bus_b.IDEXE_RD,
                 bus_b.IDEXE_RS1data, bus_b.IDEXE_RS2data, bus_b.IDEXE_Imm, bus_b.IDEXE_PC,
                 bus_b.IDEXE_WB, bus_b.IDEXE_M, bus_b.IDEXE_EX};
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [151:0] o, input logic [151:0] e);
        n_vec++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic check_all(input string tag);
        chk($sformatf("%s_A_pcw",  tag), 152'(pcw_a), 152'(model_pcw(0)));
        chk($sformatf("%s_A_ifw",  tag), 152'(ifw_a), 152'(model_pcw(0)));
        chk($sformatf("%s_A_cnt",  tag), 152'(sc_a),  152'(m_cnt[0]));
        chk($sformatf("%s_A_regs", tag), obs(0),      m_reg[0]);
        chk($sformatf("%s_B_pcw",  tag), 152'(pcw_b), 152'(model_pcw(1)));
        chk($sformatf("%s_B_ifw",  tag), 152'(ifw_b), 152'(model_pcw(1)));
        chk($sformatf("%s_B_cnt",  tag), 152'(sc_b),  152'(m_cnt[1]));
        chk($sformatf("%s_B_regs", tag), obs(1),      m_reg[1]);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_reg[k] = '0;
            m_rem[k] = 0;
            m_cnt[k] = 0;
        end
    endtask

    task automatic model_clock();
        for (int k = 0; k < 2; k++) begin
            logic hz;
            hz = model_hz(k);
            if (flush) begin
                m_reg[k] = '0;
                m_rem[k] = 0;
            end else if (m_rem[k] > 0) begin
                m_reg[k] = '0;
                m_rem[k] = m_rem[k] - 1;
                if (m_cnt[k] < cmax[k]) m_cnt[k] = m_cnt[k] + 1;
            end else if (hz) begin
                m_reg[k] = '0;
                m_rem[k] = lsc[k] - 1;
                if (m_cnt[k] < cmax[k]) m_cnt[k] = m_cnt[k] + 1;
            end else begin
                m_reg[k] = cur;
            end
        end
    endtask

    // One clock: apply inputs at the falling edge, check, then advance model.
    task automatic step(input string tag, input id_t v, input logic f);
        @(negedge clk_i);
        drive(v, f);
        #1;
        check_all(tag);
        @(posedge clk_i);
        model_clock();
    endtask

    task automatic release_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        model_clock();
    endtask

    id_t idle, lw5, use5, lw0, use0, st5, nv5, lw8, use8, lw9, use9, lw3, use3, rv;

    initial begin
        idle = '0;
        model_reset();
        drive(idle, 1'b0);

        // Reset state
        @(negedge clk_i);
        #1;
        check_all("reset");
        release_reset();

        // Load-use: lw x5 then add using x5
        lw5  = mk(1'b1, 5'd2, 5'd0, 5'd5, 2'b11, 2'b01, 4'b0001);
        use5 = mk(1'b1, 5'd5, 5'd6, 5'd7, 2'b01, 2'b00, 4'b0100);
        step("lu_lw",   lw5,  1'b0);
        step("lu_use",  use5, 1'b0);
        for (int i = 0; i < 4; i++) step("lu_hold", use5, 1'b0);
        for (int i = 0; i < 3; i++) step("idle", idle, 1'b0);

        // No false hazards: rd=0, non-load, invalid consumer
        lw0  = mk(1'b1, 5'd1, 5'd1, 5'd0, 2'b11, 2'b01, 4'b0001);
        use0 = mk(1'b1, 5'd0, 5'd0, 5'd4, 2'b01, 2'b00, 4'b0100);
        st5  = mk(1'b1, 5'd1, 5'd2, 5'd5, 2'b01, 2'b10, 4'b0001);
        nv5  = mk(1'b0, 5'd5, 5'd5, 5'd6, 2'b01, 2'b00, 4'b0100);
        step("nf_lw0",  lw0,  1'b0);
        step("nf_use0", use0, 1'b0);
        step("nf_st5",  st5,  1'b0);
        step("nf_use5", use5, 1'b0);
        step("nf_lw5",  lw5,  1'b0);
        step("nf_nv5",  nv5,  1'b0);
        step("nf_post", idle, 1'b0);

        // Flush beats a simultaneous hazard
        step("fh_lw",   lw5,  1'b0);
        step("fh_both", use5, 1'b1);
        step("fh_next", use5, 1'b0);
        for (int i = 0; i < 3; i++) step("idle", idle, 1'b0);

        // Multi-cycle stall on B, flushed on its second bubble
        lw8  = mk(1'b1, 5'd3, 5'd0, 5'd8, 2'b11, 2'b01, 4'b0001);
        use8 = mk(1'b1, 5'd1, 5'd8, 5'd9, 2'b01, 2'b00, 4'b0100);
        step("ms_lw",    lw8,  1'b0);
        step("ms_b1",    use8, 1'b0);
        step("ms_flush", use8, 1'b1);
        step("ms_run",   use8, 1'b0);
        step("ms_post",  idle, 1'b0);
        // Full three-bubble stall on B
        step("ms3_lw",   lw8,  1'b0);
        for (int i = 0; i < 4; i++) step("ms3_use", use8, 1'b0);
        for (int i = 0; i < 3; i++) step("idle", idle, 1'b0);

        // Asynchronous reset while B is mid-stall
        lw9  = mk(1'b1, 5'd0, 5'd0, 5'd9, 2'b11, 2'b01, 4'b0001);
        use9 = mk(1'b1, 5'd9, 5'd0, 5'd10, 2'b01, 2'b00, 4'b0100);
        step("ar_lw",  lw9,  1'b0);
        step("ar_use", use9, 1'b0);
        @(negedge clk_i);
        drive(use9, 1'b0);
        #1;
        check_all("ar_pre");
        #2;
        rst_i = 1'b0;
        #1;
        model_reset();
        check_all("ar_async");
        @(posedge clk_i);
        release_reset();
        step("ar_after", use9, 1'b0);
        for (int i = 0; i < 3; i++) step("idle", idle, 1'b0);

        // Counter saturation on A (4-bit)
        lw3  = mk(1'b1, 5'd0, 5'd0, 5'd3, 2'b11, 2'b01, 4'b0001);
        use3 = mk(1'b1, 5'd3, 5'd1, 5'd2, 2'b01, 2'b00, 4'b0100);
        for (int i = 0; i < 20; i++) begin
            step("sat_lw",  lw3,  1'b0);
            step("sat_use", use3, 1'b0);
            step("sat_ld",  use3, 1'b0);
        end
        @(negedge clk_i);
        #1;
        chk("sat_hold_A", 152'(sc_a), 152'(15));

        // Randomized traffic with a small register range to provoke hazards
        for (int i = 0; i < 300; i++) begin
            rv = mk(($urandom_range(0, 7) != 0),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
            step("rnd", rv, ($urandom_range(0, 9) == 0));
        end

        @(negedge clk_i);
        drive(idle, 1'b0);
        #1;
        check_all("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
